branch_target_table: RTL and testbench

//  Programmable branch-target table: the successor of the fixed 8-entry jump-offset lookup.

---
 rtl/branch_target_table.sv | 100 ++++++++++
 tb/tb_branch_target_table.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_table.sv
// Programmable branch-target table: maps a branch pointer to a next-PC value,
// either PC-relative or absolute, with a registered one-cycle lookup.
module branch_target_table #(
    parameter int ADDR_W = 3,
    parameter int PC_W   = 10
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [PC_W-1:0]   WrData,
    input  logic              WrAbs,
    input  logic              Lock,
    input  logic              RdReq,
    input  logic [ADDR_W-1:0] RdAddr,
    input  logic [PC_W-1:0]   CurPC,
    output logic              RdValid,
    output logic [PC_W-1:0]   NextPC,
    output logic              IsAbs,
    output logic              Locked
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef struct packed {
        logic            is_abs;
        logic [PC_W-1:0] value;
    } entry_t;

    entry_t          table_q [DEPTH];
    logic            locked_q;
    logic            rd_valid_q;
    logic [PC_W-1:0] next_pc_q;
    logic            is_abs_q;

    logic            wr_ok;
    entry_t          wr_entry;
    entry_t          rd_entry;
    logic [PC_W-1:0] next_pc_d;

    // Legacy jump offsets, sign-extended; deeper tables pad with +1.
    function automatic entry_t default_entry(input int idx);
        int offs;
        case (idx)
            0:       offs = 2;
            1:       offs = -5;
            2:       offs = -6;
            3:       offs = -7;
            4:       offs = -8;
            5:       offs = -13;
            6:       offs = -14;
            7:       offs = -17;
            default: offs = 1;
        endcase
        return '{is_abs: 1'b0, value: PC_W'(offs)};
    endfunction

    always_comb begin
        wr_ok    = WrEn && !locked_q;
        wr_entry = '{is_abs: WrAbs, value: WrData};
        rd_entry = table_q[RdAddr];
        // Write-first bypass so a same-cycle write is visible to the lookup.
        if (wr_ok && (WrAddr == RdAddr)) begin
            rd_entry = wr_entry;
        end
        next_pc_d = rd_entry.is_abs ? rd_entry.value : CurPC + rd_entry.value;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            // NOTE: the table is a register array, not a RAM, because reset must
            // reload every entry with its default in a single cycle.
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= default_entry(i);
            end
            locked_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            next_pc_q  <= '0;
            is_abs_q   <= 1'b0;
        end else begin
            if (wr_ok) begin
                table_q[WrAddr] <= wr_entry;
            end
            if (Lock) begin
                locked_q <= 1'b1;
            end
            rd_valid_q <= RdReq;
            if (RdReq) begin
                next_pc_q <= next_pc_d;
                is_abs_q  <= rd_entry.is_abs;
            end
        end
    end

    assign RdValid = rd_valid_q;
    assign NextPC  = next_pc_q;
    assign IsAbs   = is_abs_q;
    assign Locked  = locked_q;

endmodule

// File: tb/tb_branch_target_table.sv
// Bench for branch_target_table: two instances (3/10 and 4/16) driven by directed
// and random stimulus, compared every cycle against a table-level reference model.
module tb_branch_target_table;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Index 0 drives the ADDR_W=3/PC_W=10 instance, index 1 the ADDR_W=4/PC_W=16 one.
    logic        rst     [2];
    logic        wr_en   [2];
    logic [3:0]  wr_addr [2];
    logic [15:0] wr_data [2];
    logic        wr_abs  [2];
    logic        lock_p  [2];
    logic        rd_req  [2];
    logic [3:0]  rd_addr [2];
    logic [15:0] cur_pc  [2];

    logic        rd_valid0, is_abs0, locked0;
    logic [9:0]  next_pc0;
    logic        rd_valid1, is_abs1, locked1;
    logic [15:0] next_pc1;

    branch_target_table #(.ADDR_W(3), .PC_W(10)) u_dut0 (
        .Clk(clk), .Reset(rst[0]), .WrEn(wr_en[0]), .WrAddr(wr_addr[0][2:0]),
        .WrData(wr_data[0][9:0]), .WrAbs(wr_abs[0]), .Lock(lock_p[0]),
        .RdReq(rd_req[0]), .RdAddr(rd_addr[0][2:0]), .CurPC(cur_pc[0][9:0]),
        .RdValid(rd_valid0), .NextPC(next_pc0), .IsAbs(is_abs0), .Locked(locked0)
    );

    branch_target_table #(.ADDR_W(4), .PC_W(16)) u_dut1 (
        .Clk(clk), .Reset(rst[1]), .WrEn(wr_en[1]), .WrAddr(wr_addr[1]),
        .WrData(wr_data[1]), .WrAbs(wr_abs[1]), .Lock(lock_p[1]),
        .RdReq(rd_req[1]), .RdAddr(rd_addr[1]), .CurPC(cur_pc[1]),
        .RdValid(rd_valid1), .NextPC(next_pc1), .IsAbs(is_abs1), .Locked(locked1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          pcw   [2] = '{10, 16};
    int          depth [2] = '{8, 16};
    int          mdl_val [2][16];
    bit          mdl_abs [2][16];
    bit          mdl_lock [2];
    bit          e_valid [2];
    int          e_pc    [2];
    bit          e_abs   [2];
    bit          chk_en  [2] = '{1'b0, 1'b0};

    function automatic int mask_of(input int i);
        return (1 << pcw[i]) - 1;
    endfunction

    function automatic int dflt(input int k);
        int offs [8] = '{2, -5, -6, -7, -8, -13, -14, -17};
        return (k < 8) ? offs[k] : 1;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                for (int k = 0; k < 16; k++) begin
                    mdl_val[i][k] = dflt(k) & mask_of(i);
                    mdl_abs[i][k] = 1'b0;
                end
                mdl_lock[i] = 1'b0;
                e_valid[i]  = 1'b0;
                e_pc[i]     = 0;
                e_abs[i]    = 1'b0;
                chk_en[i]   = 1'b1;
            end else begin
                int a;
                if (wr_en[i] && !mdl_lock[i]) begin
                    a = int'(wr_addr[i]) % depth[i];
                    mdl_val[i][a] = int'(wr_data[i]) & mask_of(i);
                    mdl_abs[i][a] = wr_abs[i];
                end
                if (lock_p[i]) mdl_lock[i] = 1'b1;
                e_valid[i] = rd_req[i];
                if (rd_req[i]) begin
                    a = int'(rd_addr[i]) % depth[i];
                    e_abs[i] = mdl_abs[i][a];
                    e_pc[i]  = mdl_abs[i][a] ? mdl_val[i][a]
                                             : (int'(cur_pc[i]) + mdl_val[i][a]) & mask_of(i);
                end
            end
        end
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (chk_en[0]) begin
            check("m0_rdvalid", rd_valid0, e_valid[0]);
            check("m0_nextpc",  next_pc0,  e_pc[0]);
            check("m0_isabs",   is_abs0,   e_abs[0]);
            check("m0_locked",  locked0,   mdl_lock[0]);
        end
        if (chk_en[1]) begin
            check("m1_rdvalid", rd_valid1, e_valid[1]);
            check("m1_nextpc",  next_pc1,  e_pc[1]);
            check("m1_isabs",   is_abs1,   e_abs[1]);
            check("m1_locked",  locked1,   mdl_lock[1]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_pulses();
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b0; wr_en[i] = 1'b0; lock_p[i] = 1'b0; rd_req[i] = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_pulses();
    endtask

    task automatic req(input int i, input int p, input int pc);
        rd_req[i] = 1'b1; rd_addr[i] = 4'(p); cur_pc[i] = 16'(pc);
    endtask

    task automatic wr(input int i, input int a, input int d, input bit ab);
        wr_en[i] = 1'b1; wr_addr[i] = 4'(a); wr_data[i] = 16'(d); wr_abs[i] = ab;
    endtask

    int stream_exp [8] = '{'h102, 'h0FB, 'h0FA, 'h0F9, 'h0F8, 'h0F3, 'h0F2, 'h0EF};

    initial begin
        for (int i = 0; i < 2; i++) begin
            wr_addr[i] = '0; wr_data[i] = '0; wr_abs[i] = 1'b0;
            rd_addr[i] = '0; cur_pc[i] = '0;
        end
        clear_pulses();
        rst[0] = 1'b1; rst[1] = 1'b1;
        tick();
        check("reset_rdvalid", rd_valid0, 0);
        check("reset_nextpc",  next_pc0,  0);
        check("reset_locked",  locked0,   0);

        // Relative lookup and wrap in both directions.
        req(0, 1, 'h020); tick();
        check("t1_valid", rd_valid0, 1);
        check("t1_pc",    next_pc0,  'h01B);
        check("t1_abs",   is_abs0,   0);
        req(0, 7, 'h005); tick();
        check("t2_wrap_low", next_pc0, 'h3F4);
        req(0, 0, 'h3FF); tick();
        check("t2_wrap_high", next_pc0, 'h001);
        tick();
        check("hold_valid", rd_valid0, 0);
        check("hold_pc",    next_pc0,  'h001);

        // Absolute entry and write-first bypass.
        wr(0, 2, 'h155, 1'b1); tick();
        req(0, 2, 'h100); tick();
        check("t3_abs_pc", next_pc0, 'h155);
        check("t3_abs_bit", is_abs0, 1);
        wr(0, 2, 'h0AA, 1'b1); req(0, 2, 'h100); tick();
        check("t3_bypass", next_pc0, 'h0AA);

        // Lock with same-cycle write, then a blocked write.
        wr(0, 3, 4, 1'b0); lock_p[0] = 1'b1; tick();
        check("t4_locked", locked0, 1);
        wr(0, 3, 9, 1'b0); tick();
        req(0, 3, 'h010); tick();
        check("t4_pc", next_pc0, 'h014);

        // Back-to-back stream over defaults, then reset mid-stream.
        rst[0] = 1'b1; tick();
        for (int p = 0; p < 8; p++) begin
            req(0, p, 'h100);
            if (p == 0) lock_p[0] = 1'b1;
            tick();
            check("t5_valid", rd_valid0, 1);
            check("t5_pc",    next_pc0,  stream_exp[p]);
        end
        req(0, 2, 'h100); rst[0] = 1'b1; tick();
        check("t5_rst_valid",  rd_valid0, 0);
        check("t5_rst_locked", locked0,   0);
        req(0, 2, 'h100); tick();
        check("t5_restored", next_pc0, 'h0FA);

        // Wide instance: padding entries and wrap at 16 bits.
        req(1, 8, 'h1234); tick();
        check("t6_pad", next_pc1, 'h1235);
        req(1, 7, 'h0000); tick();
        check("t6_e7", next_pc1, 'hFFEF);
        req(1, 15, 'hFFFF); tick();
        check("t6_wrap", next_pc1, 'h0000);

        // Random traffic on both instances, checked by the model every cycle.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                rst[i]     = ($urandom_range(0, 63) == 0);
                lock_p[i]  = ($urandom_range(0, 39) == 0);
                wr_en[i]   = ($urandom_range(0, 2) == 0);
                wr_addr[i] = 4'($urandom_range(0, depth[i] - 1));
                wr_data[i] = 16'($urandom() & mask_of(i));
                wr_abs[i]  = 1'($urandom_range(0, 1));
                rd_req[i]  = ($urandom_range(0, 3) != 0);
                rd_addr[i] = ($urandom_range(0, 3) == 0) ? wr_addr[i]
                                                          : 4'($urandom_range(0, depth[i] - 1));
                cur_pc[i]  = 16'($urandom() & mask_of(i));
            end
            tick();
        end
        tick();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
